// File: rtl/ps2_keyboard_rx_if.sv
// Valid/ready scan-code port between the PS/2 receiver (master) and the key decoder (slave).
interface ps2_keyboard_rx_if;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/ps2_keyboard_rx.sv
// PS/2 device-to-host receiver: synchronisers, 11-bit deframer, scan-code FIFO, sticky errors.
// Optional frame-abort on PS/2 clock inactivity is enabled by defining PS2_RX_TIMEOUT_EN.
module ps2_keyboard_rx #(
  parameter int SYNC_STAGES    = 3,
  parameter int DEPTH          = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    ps2_clk,
  input  logic                    ps2_data,
  ps2_keyboard_rx_if.master       out_if,
  output logic [$clog2(DEPTH):0]  fifo_level,
  output logic                    frame_err,
  output logic                    overflow,
  input  logic                    err_clr
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

  function automatic logic odd_parity(input logic [8:0] v);
    return ^v;
  endfunction

  logic [SYNC_STAGES-1:0] clk_sync_r;
  logic [SYNC_STAGES-1:0] data_sync_r;
  logic                   clk_prev_r;
  logic                   clk_s;
  logic                   data_s;
  logic                   fall_s;
  logic [3:0]             count_r;
  logic [9:0]             bits_r;
  logic                   frame_done_s;
  logic                   good_s;
  logic                   bad_s;
  logic                   timeout_s;
  logic [7:0]             mem_r [DEPTH];
  logic [PW-1:0]          wr_ptr_r;
  logic [PW-1:0]          rd_ptr_r;
  logic [PW-1:0]          rd_ptr_nxt_s;
  logic [LW-1:0]          level_r;
  logic [LW-1:0]          level_nxt_s;
  logic                   full_s;
  logic                   pop_s;
  logic                   push_s;
  logic                   drop_s;
  logic [7:0]             head_nxt_s;
  logic [7:0]             out_data_r;
  logic                   out_valid_r;
  logic                   frame_err_r;
  logic                   overflow_r;

  assign clk_s        = clk_sync_r[SYNC_STAGES-1];
  assign data_s       = data_sync_r[SYNC_STAGES-1];
  assign fall_s       = clk_prev_r & ~clk_s;
  assign frame_done_s = fall_s && (count_r == 4'd10);
  // bits_r[0] is the start bit, bits_r[9] the parity bit; data_s is the stop bit now.
  assign good_s       = frame_done_s && !bits_r[0] && data_s && odd_parity(bits_r[9:1]);
  assign bad_s        = frame_done_s && !good_s;

  // Input synchronisers idle high, plus the edge-detect history flop.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      clk_sync_r  <= '1;
      data_sync_r <= '1;
      clk_prev_r  <= 1'b1;
    end else begin
      clk_sync_r  <= {clk_sync_r[SYNC_STAGES-2:0], ps2_clk};
      data_sync_r <= {data_sync_r[SYNC_STAGES-2:0], ps2_data};
      clk_prev_r  <= clk_s;
    end
  end

  // Bit counter and LSB-first shift register; bits enter at the top.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_r <= 4'd0;
      bits_r  <= 10'd0;
    end else if (timeout_s) begin
      count_r <= 4'd0;
    end else if (fall_s) begin
      if (count_r == 4'd10) begin
        count_r <= 4'd0;
      end else begin
        count_r <= count_r + 4'd1;
        bits_r  <= {data_s, bits_r[9:1]};
      end
    end else begin
      count_r <= count_r;
    end
  end

`ifdef PS2_RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] idle_cnt_r;

  assign timeout_s = (count_r != 4'd0) && !fall_s && (idle_cnt_r == TW'(TIMEOUT_CYCLES - 1));

  // Inactivity counter; only runs while a frame is partially received.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      idle_cnt_r <= '0;
    end else if ((count_r == 4'd0) || fall_s || timeout_s) begin
      idle_cnt_r <= '0;
    end else begin
      idle_cnt_r <= idle_cnt_r + TW'(1);
    end
  end
`else
  assign timeout_s = 1'b0;
`endif

  // FIFO next-state: a pop in the same cycle frees the slot for a push into a full FIFO.
  always_comb begin
    full_s       = (level_r == FULL_LEVEL);
    pop_s        = out_valid_r && out_if.out_ready;
    push_s       = good_s && (!full_s || pop_s);
    drop_s       = good_s && full_s && !pop_s;
    rd_ptr_nxt_s = rd_ptr_r;
    level_nxt_s  = level_r;
    head_nxt_s   = 8'h00;
    if (pop_s) begin
      rd_ptr_nxt_s = rd_ptr_r + PW'(1);
    end else begin
      rd_ptr_nxt_s = rd_ptr_r;
    end
    case ({push_s, pop_s})
      2'b10:   level_nxt_s = level_r + LW'(1);
      2'b01:   level_nxt_s = level_r - LW'(1);
      default: level_nxt_s = level_r;
    endcase
    // The incoming byte becomes the head when it lands in the slot the head will point at.
    if (push_s && (wr_ptr_r == rd_ptr_nxt_s)) begin
      head_nxt_s = bits_r[8:1];
    end else begin
      head_nxt_s = mem_r[rd_ptr_nxt_s];
    end
  end

  // FIFO storage, pointers, and registered head/valid/level.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 8'h00;
      end
      wr_ptr_r    <= '0;
      rd_ptr_r    <= '0;
      level_r     <= '0;
      out_valid_r <= 1'b0;
      out_data_r  <= 8'h00;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= bits_r[8:1];
        wr_ptr_r        <= wr_ptr_r + PW'(1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      rd_ptr_r    <= rd_ptr_nxt_s;
      level_r     <= level_nxt_s;
      out_valid_r <= (level_nxt_s != '0);
      if (level_nxt_s != '0) begin
        out_data_r <= head_nxt_s;
      end else begin
        out_data_r <= 8'h00;
      end
    end
  end

  // Sticky error flags; a clear wins over a same-cycle set.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      frame_err_r <= 1'b0;
      overflow_r  <= 1'b0;
    end else if (err_clr) begin
      frame_err_r <= 1'b0;
      overflow_r  <= 1'b0;
    end else begin
      if (bad_s || timeout_s) begin
        frame_err_r <= 1'b1;
      end else begin
        frame_err_r <= frame_err_r;
      end
      if (drop_s) begin
        overflow_r <= 1'b1;
      end else begin
        overflow_r <= overflow_r;
      end
    end
  end

  assign out_if.out_data  = out_data_r;
  assign out_if.out_valid = out_valid_r;
  assign fifo_level       = level_r;
  assign frame_err        = frame_err_r;
  assign overflow         = overflow_r;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Directed self-checking bench for ps2_keyboard_rx; PS/2 bit period is 30 clk cycles.
module tb_ps2_keyboard_rx;
  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       err_clr = 1'b0;
  logic [3:0] fifo_level;
  logic       frame_err;
  logic       overflow;
  int         checks = 0;
  int         failures = 0;
  int         valid_cycles = 0;
  logic [7:0] rx_q [$];
  logic [7:0] exp_b;

  ps2_keyboard_rx_if u_if ();

  ps2_keyboard_rx #(.SYNC_STAGES(3), .DEPTH(DEPTH), .TIMEOUT_CYCLES(1000)) dut (
    .clk(clk), .resetn(resetn), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .out_if(u_if), .fifo_level(fifo_level), .frame_err(frame_err),
    .overflow(overflow), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  // Record every accepted byte and count cycles with out_valid high.
  always @(negedge clk) begin
    if (u_if.out_valid) valid_cycles++;
    if (u_if.out_valid && u_if.out_ready) rx_q.push_back(u_if.out_data);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ps2_bit(input logic b);
    ps2_data = b; tick(7);
    ps2_clk = 1'b0; tick(15);
    ps2_clk = 1'b1; tick(8);
  endtask

  function automatic logic [10:0] mk(input logic [7:0] d, input logic par, input logic stop, input logic start);
    return {stop, par, d, start};
  endfunction

  task automatic send_bits(input logic [10:0] f, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) ps2_bit(f[i]);
    ps2_data = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] d);
    send_bits(mk(d, ~^d, 1'b1, 1'b0), 0, 10);
    tick(5);
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1; tick(1); err_clr = 1'b0; tick(1);
  endtask

  task automatic test_reset();
    resetn = 1'b0; u_if.out_ready = 1'b1; tick(5);
    checks++; if (u_if.out_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got %b exp 0", u_if.out_valid); end
    checks++; if (u_if.out_data !== 8'h00) begin failures++; $display("FAIL rst_data got %h exp 00", u_if.out_data); end
    checks++; if (fifo_level !== 4'd0) begin failures++; $display("FAIL rst_level got %0d exp 0", fifo_level); end
    checks++; if (frame_err !== 1'b0 || overflow !== 1'b0) begin failures++; $display("FAIL rst_flags got %b%b exp 00", frame_err, overflow); end
    resetn = 1'b1; tick(5);
  endtask

  task automatic test_good_byte();
    rx_q.delete(); valid_cycles = 0;
    send_byte(8'h1C);
    checks++; if (rx_q.size() !== 1) begin failures++; $display("FAIL t1_count got %0d exp 1", rx_q.size()); end
    else begin checks++; if (rx_q[0] !== 8'h1C) begin failures++; $display("FAIL t1_data got %h exp 1c", rx_q[0]); end end
    checks++; if (valid_cycles !== 1) begin failures++; $display("FAIL t1_valid_cycles got %0d exp 1", valid_cycles); end
    checks++; if (fifo_level !== 4'd0) begin failures++; $display("FAIL t1_level got %0d exp 0", fifo_level); end
    checks++; if (frame_err !== 1'b0 || overflow !== 1'b0) begin failures++; $display("FAIL t1_flags got %b%b exp 00", frame_err, overflow); end
  endtask

  task automatic test_frame_errors();
    rx_q.delete();
    send_bits(mk(8'h1C, 1'b1, 1'b1, 1'b0), 0, 10); tick(5);
    checks++; if (frame_err !== 1'b1) begin failures++; $display("FAIL t2_parity_err got %b exp 1", frame_err); end
    checks++; if (rx_q.size() !== 0 || fifo_level !== 4'd0) begin failures++; $display("FAIL t2_no_write got %0d/%0d exp 0/0", rx_q.size(), fifo_level); end
    pulse_clr();
    checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL t2_clr got %b exp 0", frame_err); end
    send_bits(mk(8'h1C, 1'b0, 1'b1, 1'b1), 0, 10); tick(5);
    checks++; if (frame_err !== 1'b1 || rx_q.size() !== 0) begin failures++; $display("FAIL t2_start_err got %b/%0d exp 1/0", frame_err, rx_q.size()); end
    pulse_clr();
    send_byte(8'hF0);
    checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL t2_f0_err got %b exp 0", frame_err); end
    checks++; if (rx_q.size() !== 1 || rx_q[0] !== 8'hF0) begin failures++; $display("FAIL t2_f0_data got n=%0d exp 1 byte f0", rx_q.size()); end
  endtask

  task automatic test_overflow();
    rx_q.delete(); u_if.out_ready = 1'b0;
    for (int i = 1; i <= 9; i++) send_byte(8'(i));
    checks++; if (fifo_level !== 4'd8) begin failures++; $display("FAIL t3_level got %0d exp 8", fifo_level); end
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL t3_overflow got %b exp 1", overflow); end
    checks++; if (u_if.out_valid !== 1'b1 || u_if.out_data !== 8'h01) begin failures++; $display("FAIL t3_head got %b/%h exp 1/01", u_if.out_valid, u_if.out_data); end
    u_if.out_ready = 1'b1; tick(20);
    checks++; if (rx_q.size() !== 8) begin failures++; $display("FAIL t3_drain_count got %0d exp 8", rx_q.size()); end
    for (int i = 0; i < 8 && i < rx_q.size(); i++) begin
      exp_b = 8'(i + 1);
      checks++; if (rx_q[i] !== exp_b) begin failures++; $display("FAIL t3_order[%0d] got %h exp %h", i, rx_q[i], exp_b); end
    end
    checks++; if (u_if.out_valid !== 1'b0 || fifo_level !== 4'd0) begin failures++; $display("FAIL t3_empty got %b/%0d exp 0/0", u_if.out_valid, fifo_level); end
  endtask

  task automatic test_full_push_pop();
    rx_q.delete(); u_if.out_ready = 1'b0;
    for (int i = 0; i < 8; i++) send_byte(8'h11 + 8'(i));
    pulse_clr();
    checks++; if (fifo_level !== 4'd8 || overflow !== 1'b0) begin failures++; $display("FAIL t4_pre got %0d/%b exp 8/0", fifo_level, overflow); end
    send_bits(mk(8'h5A, 1'b1, 1'b1, 1'b0), 0, 9);
    ps2_data = 1'b1; tick(7);
    ps2_clk = 1'b0; tick(3);
    u_if.out_ready = 1'b1; tick(1); u_if.out_ready = 1'b0;
    tick(11); ps2_clk = 1'b1; tick(8);
    checks++; if (fifo_level !== 4'd8) begin failures++; $display("FAIL t4_level got %0d exp 8", fifo_level); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL t4_overflow got %b exp 0", overflow); end
    checks++; if (rx_q.size() !== 1 || rx_q[0] !== 8'h11) begin failures++; $display("FAIL t4_pop got n=%0d exp 1 byte 11", rx_q.size()); end
    u_if.out_ready = 1'b1; tick(20);
    checks++; if (rx_q.size() !== 9) begin failures++; $display("FAIL t4_drain_count got %0d exp 9", rx_q.size()); end
    else begin
      checks++; if (rx_q[7] !== 8'h18 || rx_q[8] !== 8'h5A) begin failures++; $display("FAIL t4_tail got %h %h exp 18 5a", rx_q[7], rx_q[8]); end
    end
  endtask

  task automatic test_timeout();
    rx_q.delete(); u_if.out_ready = 1'b1;
    send_bits(mk(8'h5A, 1'b1, 1'b1, 1'b0), 0, 3);
    tick(1100);
`ifdef PS2_RX_TIMEOUT_EN
    checks++; if (frame_err !== 1'b1) begin failures++; $display("FAIL t5_timeout got %b exp 1", frame_err); end
    pulse_clr();
    send_byte(8'h5A);
`else
    checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL t5_no_timeout got %b exp 0", frame_err); end
    send_bits(mk(8'h5A, 1'b1, 1'b1, 1'b0), 4, 10); tick(5);
`endif
    checks++; if (rx_q.size() !== 1 || rx_q[0] !== 8'h5A) begin failures++; $display("FAIL t5_data got n=%0d exp 1 byte 5a", rx_q.size()); end
    checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL t5_err_after got %b exp 0", frame_err); end
  endtask

  task automatic test_reset_mid_frame();
    u_if.out_ready = 1'b0;
    send_byte(8'h77);
    send_bits(mk(8'h1C, 1'b1, 1'b1, 1'b0), 0, 10); tick(5);
    checks++; if (u_if.out_data !== 8'h77 || frame_err !== 1'b1) begin failures++; $display("FAIL t6_pre got %h/%b exp 77/1", u_if.out_data, frame_err); end
    send_bits(mk(8'h33, 1'b1, 1'b1, 1'b0), 0, 5);
    resetn = 1'b0; tick(3);
    checks++; if (u_if.out_valid !== 1'b0 || u_if.out_data !== 8'h00 || fifo_level !== 4'd0) begin failures++; $display("FAIL t6_rst_out got %b/%h/%0d exp 0/00/0", u_if.out_valid, u_if.out_data, fifo_level); end
    checks++; if (frame_err !== 1'b0 || overflow !== 1'b0) begin failures++; $display("FAIL t6_rst_flags got %b%b exp 00", frame_err, overflow); end
    resetn = 1'b1; tick(3);
    rx_q.delete(); u_if.out_ready = 1'b1; tick(5);
    checks++; if (rx_q.size() !== 0) begin failures++; $display("FAIL t6_spurious got %0d exp 0", rx_q.size()); end
    send_byte(8'h29);
    checks++; if (rx_q.size() !== 1 || rx_q[0] !== 8'h29) begin failures++; $display("FAIL t6_data got n=%0d exp 1 byte 29", rx_q.size()); end
    checks++; if (frame_err !== 1'b0 || fifo_level !== 4'd0) begin failures++; $display("FAIL t6_after got %b/%0d exp 0/0", frame_err, fifo_level); end
  endtask

  initial begin
    u_if.out_ready = 1'b1;
    test_reset();
    test_good_byte();
    test_frame_errors();
    test_overflow();
    test_full_push_pop();
    test_timeout();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
